// File: rtl/text_buffer_pkg.sv
// Shared character codes and writer FSM states for the text buffer writer.
package text_buffer_pkg;

    localparam logic [7:0] CHAR_SPACE = 8'h20;
    localparam logic [7:0] CHAR_LF    = 8'h0A;
    localparam logic [7:0] CHAR_CR    = 8'h0D;
    localparam logic [7:0] CHAR_BS    = 8'h08;
    localparam logic [7:0] CHAR_HT    = 8'h09;

    typedef enum logic [1:0] {
        CLEAR_ALL  = 2'd0,
        IDLE       = 2'd1,
        CLEAR_LINE = 2'd2,
        TAB        = 2'd3
    } wr_state_t;

endpackage

// File: rtl/text_cursor.sv
// Text cursor column/row counters; the writer FSM issues one command set per cycle.
module text_cursor #(
    parameter int ROWS  = 30,
    parameter int COL_W = 7,
    parameter int ROW_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    input  logic             home,
    input  logic             adv,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             wrap
);

    // Pulses in the cycle the row advance is committed, so the FSM can start the line clear.
    assign wrap = adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else begin
            if (home)
                col <= '0;
            else if (inc)
                col <= col + 1'b1;
            else if (dec)
                col <= col - 1'b1;
            if (adv)
                row <= (row == ROW_W'(ROWS - 1)) ? '0 : row + 1'b1;
        end
    end

endmodule

// File: rtl/text_buffer_writer.sv
// Character buffer writer: cursor tracking, control codes, screen/line clears.
// Define TEXT_BUFFER_WRITER_TAB_EN to expand HT to spaces up to the next 8-column stop.
module text_buffer_writer
    import text_buffer_pkg::*;
#(
    parameter int SCREEN_COLS = 80,
    parameter int SCREEN_ROWS = 30,
    parameter int COL_W       = $clog2(SCREEN_COLS),
    parameter int ROW_W       = $clog2(SCREEN_ROWS),
    parameter int ADDR_W      = $clog2(SCREEN_COLS * SCREEN_ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_char,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [COL_W-1:0]  cursor_col,
    output logic [ROW_W-1:0]  cursor_row,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ALL  = ADDR_W'(SCREEN_COLS * SCREEN_ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(SCREEN_COLS - 1);

    wr_state_t         state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] row_base;
    logic              xfer, last_col, row_wrap;
    logic              c_inc, c_dec, c_home, c_adv;

    assign xfer     = in_valid & in_ready;
    assign last_col = (cursor_col == COL_W'(SCREEN_COLS - 1));
    assign row_base = ADDR_W'(cursor_row) * ADDR_W'(SCREEN_COLS);

`ifdef TEXT_BUFFER_WRITER_TAB_EN
    logic tab_stop;
    assign tab_stop = (((32'(cursor_col) + 32'd1) & 32'd7) == 32'd0);
`endif

    always_comb begin
        c_inc  = 1'b0;
        c_dec  = 1'b0;
        c_home = 1'b0;
        c_adv  = 1'b0;
        if (state == IDLE && xfer) begin
            case (in_char)
                CHAR_LF: begin c_home = 1'b1; c_adv = 1'b1; end
                CHAR_CR: c_home = 1'b1;
                CHAR_BS: c_dec = (cursor_col != '0);
`ifdef TEXT_BUFFER_WRITER_TAB_EN
                CHAR_HT: ;
`endif
                default: begin
                    if (last_col) begin c_home = 1'b1; c_adv = 1'b1; end
                    else c_inc = 1'b1;
                end
            endcase
        end
`ifdef TEXT_BUFFER_WRITER_TAB_EN
        if (state == TAB) begin
            if (last_col) begin c_home = 1'b1; c_adv = 1'b1; end
            else c_inc = 1'b1;
        end
`endif
    end

    text_cursor #(
        .ROWS  (SCREEN_ROWS),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_cursor (
        .clk  (clk),
        .rst  (rst),
        .inc  (c_inc),
        .dec  (c_dec),
        .home (c_home),
        .adv  (c_adv),
        .col  (cursor_col),
        .row  (cursor_row),
        .wrap (row_wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLEAR_ALL;
            clr_cnt  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
        end else begin
            wr_en <= 1'b0;
            case (state)
                CLEAR_ALL: begin
                    wr_en   <= 1'b1;
                    wr_addr <= clr_cnt;
                    wr_data <= CHAR_SPACE;
                    if (clr_cnt == LAST_ALL) begin
                        state    <= IDLE;
                        clr_cnt  <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (xfer) begin
                        case (in_char)
                            CHAR_LF, CHAR_CR: ;
                            CHAR_BS: begin
                                if (c_dec) begin
                                    wr_en   <= 1'b1;
                                    wr_addr <= row_base + ADDR_W'(cursor_col) - ADDR_W'(1);
                                    wr_data <= CHAR_SPACE;
                                end
                            end
`ifdef TEXT_BUFFER_WRITER_TAB_EN
                            CHAR_HT: begin
                                state    <= TAB;
                                in_ready <= 1'b0;
                                busy     <= 1'b1;
                            end
`endif
                            default: begin
                                wr_en   <= 1'b1;
                                wr_addr <= row_base + ADDR_W'(cursor_col);
                                wr_data <= in_char;
                            end
                        endcase
                    end
                end
                CLEAR_LINE: begin
                    // cursor_row already points at the new row here
                    wr_en   <= 1'b1;
                    wr_addr <= row_base + clr_cnt;
                    wr_data <= CHAR_SPACE;
                    if (clr_cnt == LAST_LINE) begin
                        state    <= IDLE;
                        clr_cnt  <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
`ifdef TEXT_BUFFER_WRITER_TAB_EN
                TAB: begin
                    wr_en   <= 1'b1;
                    wr_addr <= row_base + ADDR_W'(cursor_col);
                    wr_data <= CHAR_SPACE;
                    if (!last_col && tab_stop) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
`endif
                default: begin
                    state   <= CLEAR_ALL;
                    clr_cnt <= '0;
                end
            endcase
            // A row advance from any state hands over to the line clear.
            if (row_wrap) begin
                state    <= CLEAR_LINE;
                clr_cnt  <= '0;
                in_ready <= 1'b0;
                busy     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_text_buffer_writer.sv
// Scoreboard bench for text_buffer_writer on an 8x4 screen.
module tb_text_buffer_writer;

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;

    logic       clk, rst, in_valid, in_ready, wr_en, busy;
    logic [7:0] in_char, wr_data;
    logic [4:0] wr_addr;
    logic [2:0] cursor_col;
    logic [1:0] cursor_row;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    text_buffer_writer #(.SCREEN_COLS(8), .SCREEN_ROWS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_char    (in_char),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_addr", int'(wr_addr), -1);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", int'(wr_addr), int'(e.addr));
                check("wr_data", int'(wr_data), int'(e.data));
            end
        end
    end

    task automatic push(input int addr, input int data);
        wr_t e;
        e.addr = 5'(addr);
        e.data = 8'(data);
        exp_q.push_back(e);
    endtask

    task automatic push_spaces(input int first, input int n);
        for (int i = 0; i < n; i++) push(first + i, 8'h20);
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic send(input logic [7:0] c);
        int n;
        wait_ready(n);
        in_valid = 1'b1;
        in_char  = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b0; in_valid = 1'b0; in_char = 8'h00;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_busy", int'(busy), 1);
        check("rst_cursor", int'({cursor_row, cursor_col}), 0);

        // 1: full clear after reset
        push_spaces(0, 32);
        rst = 1'b0;
        wait_ready(n);
        check("clear_all_cycles", n, 32);
        check("idle_busy", int'(busy), 0);
        check("idle_cursor", int'({cursor_row, cursor_col}), 0);

        // 2: two printables
        push(0, 8'h41); send(8'h41);
        push(1, 8'h42); send(8'h42);
        check("ab_col", int'(cursor_col), 2);

        // 3: a full row wraps into a line clear
        send(8'h0D);
        for (int i = 0; i < 8; i++) begin
            push(i, 8'h61 + i);
            send(8'(8'h61 + i));
        end
        push_spaces(8, 8);
        check("row_end_row", int'(cursor_row), 1);
        check("row_end_col", int'(cursor_col), 0);
        check("row_end_in_ready", int'(in_ready), 0);
        check("row_end_busy", int'(busy), 1);
        wait_ready(n);
        check("clear_line_cycles", n, 8);

        // 4: LF wraps from row 3 to row 0; CR does not write
        push_spaces(16, 8); send(8'h0A);
        push_spaces(24, 8); send(8'h0A);
        wait_ready(n);
        check("lf_row3", int'(cursor_row), 3);
        push_spaces(0, 8); send(8'h0A);
        wait_ready(n);
        check("lf_wrap_cursor", int'({cursor_row, cursor_col}), 0);
        for (int i = 0; i < 5; i++) begin
            push(i, 8'h31 + i);
            send(8'(8'h31 + i));
        end
        check("pre_cr_col", int'(cursor_col), 5);
        send(8'h0D);
        check("cr_col", int'(cursor_col), 0);
        check("cr_no_write", int'(wr_en), 0);

        // 5: BS at col 0 is a no-op; BS at col 3 row 2 blanks addr 18
        send(8'h08);
        check("bs0_no_write", int'(wr_en), 0);
        check("bs0_cursor", int'({cursor_row, cursor_col}), 0);
        push_spaces(8, 8); send(8'h0A);
        push_spaces(16, 8); send(8'h0A);
        push(16, 8'h78); send(8'h78);
        push(17, 8'h79); send(8'h79);
        push(18, 8'h7A); send(8'h7A);
        push(18, 8'h20); send(8'h08);
        check("bs_write", int'(wr_en), 1);
        check("bs_col", int'(cursor_col), 2);
        check("bs_row", int'(cursor_row), 2);

        // 6: reset in the middle of a line clear restarts the full clear
        push_spaces(24, 3); send(8'h0A);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_pending", exp_q.size(), 0);
        check("midrst_wr_en", int'(wr_en), 0);
        check("midrst_wr_addr", int'(wr_addr), 0);
        check("midrst_wr_data", int'(wr_data), 0);
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_busy", int'(busy), 1);
        check("midrst_cursor", int'({cursor_row, cursor_col}), 0);
        @(posedge clk);
        #1;
        push_spaces(0, 32);
        rst = 1'b0;
        wait_ready(n);
        check("reclear_cycles", n, 32);

`ifdef TEXT_BUFFER_WRITER_TAB_EN
        for (int i = 0; i < 5; i++) begin
            push(i, 8'h31 + i);
            send(8'(8'h31 + i));
        end
        push_spaces(5, 3);
        push_spaces(8, 8);
        send(8'h09);
        wait_ready(n);
        check("tab_cursor_row", int'(cursor_row), 1);
        check("tab_cursor_col", int'(cursor_col), 0);
`else
        push(0, 8'h09); send(8'h09);
        check("ht_printable_col", int'(cursor_col), 1);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
